mc_controller: RTL and testbench

Multicycle control unit for the team's 16-bit MIPS-style CPU. It is the producer side of the ALU control interface: it decodes the instruction opcode and funct, then sequences the datapath through fetch, decode, execute, memory and writeback.
- Drives aluop, ALU operand selects and all write enables.
- Consumes the ALU zero flag for BEQ.
- Handshakes with instruction/data memory through mem_ready.

---
 rtl/cpu_pkg.sv | 68 ++++++
 rtl/mc_controller_if.sv | 38 +++
 rtl/mc_ctrl_decode.sv | 94 +++++++++
 rtl/mc_controller.sv | 100 ++++++++++
 tb/tb_mc_controller.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multicycle CPU control path.
package cpu_pkg;

    localparam int unsigned OP_W    = 4;
    localparam int unsigned FUNCT_W = 3;
    localparam int unsigned ALUOP_W = 3;

    // Controller states
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC, ALUWB, IMMEXEC, IMMWB,
        MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, JUMP
    } state_t;

    // Opcodes (IR[15:12]); anything with bit 3 set is undefined
    localparam logic [OP_W-1:0] OP_RTYPE = 4'd0;
    localparam logic [OP_W-1:0] OP_ADDI  = 4'd1;
    localparam logic [OP_W-1:0] OP_LW    = 4'd2;
    localparam logic [OP_W-1:0] OP_SW    = 4'd3;
    localparam logic [OP_W-1:0] OP_BEQ   = 4'd4;
    localparam logic [OP_W-1:0] OP_J     = 4'd5;
    localparam logic [OP_W-1:0] OP_ANDI  = 4'd6;
    localparam logic [OP_W-1:0] OP_ORI   = 4'd7;

    // ALU operations, shared with the ALU decode
    localparam logic [ALUOP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALUOP_W-1:0] ALU_AND = 3'd2;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 3'd3;
    localparam logic [ALUOP_W-1:0] ALU_SLL = 3'd4;
    localparam logic [ALUOP_W-1:0] ALU_SRL = 3'd5;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 3'd6;
    localparam logic [ALUOP_W-1:0] ALU_NOR = 3'd7;

    // ALU operand B selects
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_TWO   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // PC source selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Full control word driven toward the datapath
    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic               alusrca;
        logic [1:0]         alusrcb;
        logic               iord;
        logic               irwrite;
        logic               pcwrite;
        logic [1:0]         pcsrc;
        logic               memwrite;
        logic               memread;
        logic               regwrite;
        logic               regdst;
        logic               memtoreg;
        logic               instr_done;
        logic               illegal;
        logic               mem_err;
    } ctrl_t;

    function automatic logic is_illegal(input logic [OP_W-1:0] op);
        return op[OP_W-1];
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath/memory control bus.
interface mc_controller_if;
    import cpu_pkg::*;

    logic [OP_W-1:0]    opcode;
    logic [FUNCT_W-1:0] funct;
    logic               zero;
    logic               mem_ready;
    logic [ALUOP_W-1:0] aluop;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic               iord;
    logic               irwrite;
    logic               pcwrite;
    logic [1:0]         pcsrc;
    logic               memwrite;
    logic               memread;
    logic               regwrite;
    logic               regdst;
    logic               memtoreg;
    logic               instr_done;
    logic               illegal;
    logic               mem_err;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output aluop, alusrca, alusrcb, iord, irwrite, pcwrite, pcsrc,
               memwrite, memread, regwrite, regdst, memtoreg,
               instr_done, illegal, mem_err
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  aluop, alusrca, alusrcb, iord, irwrite, pcwrite, pcsrc,
               memwrite, memread, regwrite, regdst, memtoreg,
               instr_done, illegal, mem_err
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational map from controller state to the datapath control word.
module mc_ctrl_decode
    import cpu_pkg::*;
(
    input  state_t             state_i,
    input  logic [OP_W-1:0]    opcode_i,
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic               zero_i,
    input  logic               mem_ready_i,
    input  logic               timeout_i,
    output ctrl_t              ctrl_o
);

    // Per-state control outputs; unlisted signals stay 0
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            FETCH: begin
                ctrl_o.memread = 1'b1;
                ctrl_o.alusrcb = SRCB_TWO;
                ctrl_o.aluop   = ALU_ADD;
                ctrl_o.pcsrc   = PCSRC_ALU;
                ctrl_o.irwrite = mem_ready_i && !timeout_i;
                ctrl_o.pcwrite = mem_ready_i && !timeout_i;
                ctrl_o.mem_err = timeout_i;
            end
            DECODE: begin
                ctrl_o.alusrcb    = SRCB_IMMSH;
                ctrl_o.aluop      = ALU_ADD;
                ctrl_o.illegal    = is_illegal(opcode_i);
                ctrl_o.instr_done = is_illegal(opcode_i);
            end
            EXEC: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_REG;
                ctrl_o.aluop   = funct_i;
            end
            ALUWB: begin
                ctrl_o.regwrite   = 1'b1;
                ctrl_o.regdst     = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            IMMEXEC: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
                case (opcode_i)
                    OP_ANDI: ctrl_o.aluop = ALU_AND;
                    OP_ORI:  ctrl_o.aluop = ALU_OR;
                    default: ctrl_o.aluop = ALU_ADD;
                endcase
            end
            IMMWB: begin
                ctrl_o.regwrite   = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            MEMADR: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
                ctrl_o.aluop   = ALU_ADD;
            end
            MEMRD: begin
                ctrl_o.memread = 1'b1;
                ctrl_o.iord    = 1'b1;
                ctrl_o.mem_err = timeout_i;
            end
            MEMWB: begin
                ctrl_o.regwrite   = 1'b1;
                ctrl_o.memtoreg   = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            MEMWR: begin
                ctrl_o.memwrite   = !timeout_i;
                ctrl_o.iord       = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
                ctrl_o.mem_err    = timeout_i;
            end
            BRANCH: begin
                ctrl_o.alusrca    = 1'b1;
                ctrl_o.alusrcb    = SRCB_REG;
                ctrl_o.aluop      = ALU_SUB;
                ctrl_o.pcsrc      = PCSRC_ALUOUT;
                ctrl_o.pcwrite    = zero_i;
                ctrl_o.instr_done = 1'b1;
            end
            JUMP: begin
                ctrl_o.pcsrc      = PCSRC_JUMP;
                ctrl_o.pcwrite    = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle CPU control unit: state register, sequencing and memory timeout.
module mc_controller
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter int unsigned TO_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mc_controller_if.master  cpu_if
);

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            wait_st_c;
    logic            timeout_c;
    ctrl_t           ctrl_c;

    // Memory wait states and the timeout condition
    always_comb begin
        wait_st_c = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
        timeout_c = (MEM_TIMEOUT != 0) && wait_st_c && !cpu_if.mem_ready
                    && (cnt_q == TO_W'(MEM_TIMEOUT));
    end

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (cpu_if.mem_ready) state_d = DECODE;
            DECODE: begin
                case (cpu_if.opcode)
                    OP_RTYPE:                 state_d = EXEC;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = IMMEXEC;
                    OP_LW, OP_SW:             state_d = MEMADR;
                    OP_BEQ:                   state_d = BRANCH;
                    OP_J:                     state_d = JUMP;
                    default:                  state_d = FETCH;
                endcase
            end
            EXEC:    state_d = ALUWB;
            IMMEXEC: state_d = IMMWB;
            MEMADR:  state_d = (cpu_if.opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD: begin
                if (timeout_c)             state_d = FETCH;
                else if (cpu_if.mem_ready) state_d = MEMWB;
            end
            MEMWR:   if (timeout_c || cpu_if.mem_ready) state_d = FETCH;
            ALUWB, IMMWB, MEMWB, BRANCH, JUMP: state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Wait counter: counts while a wait state holds, clears on any exit or re-entry
    always_comb begin
        if ((MEM_TIMEOUT != 0) && wait_st_c && !cpu_if.mem_ready && !timeout_c)
            cnt_d = cnt_q + TO_W'(1);
        else
            cnt_d = '0;
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    mc_ctrl_decode u_decode (
        .state_i     (state_q),
        .opcode_i    (cpu_if.opcode),
        .funct_i     (cpu_if.funct),
        .zero_i      (cpu_if.zero),
        .mem_ready_i (cpu_if.mem_ready),
        .timeout_i   (timeout_c),
        .ctrl_o      (ctrl_c)
    );

    assign cpu_if.aluop      = ctrl_c.aluop;
    assign cpu_if.alusrca    = ctrl_c.alusrca;
    assign cpu_if.alusrcb    = ctrl_c.alusrcb;
    assign cpu_if.iord       = ctrl_c.iord;
    assign cpu_if.irwrite    = ctrl_c.irwrite;
    assign cpu_if.pcwrite    = ctrl_c.pcwrite;
    assign cpu_if.pcsrc      = ctrl_c.pcsrc;
    assign cpu_if.memwrite   = ctrl_c.memwrite;
    assign cpu_if.memread    = ctrl_c.memread;
    assign cpu_if.regwrite   = ctrl_c.regwrite;
    assign cpu_if.regdst     = ctrl_c.regdst;
    assign cpu_if.memtoreg   = ctrl_c.memtoreg;
    assign cpu_if.instr_done = ctrl_c.instr_done;
    assign cpu_if.illegal    = ctrl_c.illegal;
    assign cpu_if.mem_err    = ctrl_c.mem_err;

endmodule

// File: tb/tb_mc_controller.sv
// Randomized instruction-level bench for mc_controller against a phase-table model.
module tb_mc_controller;

    localparam int unsigned TMO = 4;

    // Bench-side instruction phases
    localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DECODE = 2, PH_EXEC = 3, PH_ALUWB = 4,
                   PH_IMMEXEC = 5, PH_IMMWB = 6, PH_MEMADR = 7, PH_MEMRD = 8,
                   PH_MEMWB = 9, PH_MEMWR = 10, PH_BRANCH = 11, PH_JUMP = 12;

    typedef struct packed {
        logic [2:0] aluop;
        logic       srca;
        logic [1:0] srcb;
        logic       iord, irw, pcw;
        logic [1:0] pcsrc;
        logic       mw, mr, rw, rdst, m2r, done, ill, err;
    } ctl_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [3:0] cur_op;
    logic [2:0] cur_fn;
    logic       cur_z;
    int         icyc;
    int         done_at;

    mc_controller_if bus ();

    mc_controller #(.MEM_TIMEOUT(TMO), .TO_W(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cpu_if (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic ctl_t sample();
        return {bus.aluop, bus.alusrca, bus.alusrcb, bus.iord, bus.irwrite, bus.pcwrite,
                bus.pcsrc, bus.memwrite, bus.memread, bus.regwrite, bus.regdst,
                bus.memtoreg, bus.instr_done, bus.illegal, bus.mem_err};
    endfunction

    // Reference control word for one phase, straight from the instruction table
    function automatic ctl_t model(input int ph, input logic rdy, input logic z,
                                   input logic [3:0] op, input logic [2:0] fn, input logic tmo);
        ctl_t c = '0;
        case (ph)
            PH_FETCH:   begin c.mr = 1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy; c.err = tmo; end
            PH_DECODE:  begin c.srcb = 2'b11; c.ill = (op >= 4'd8); c.done = (op >= 4'd8); end
            PH_EXEC:    begin c.srca = 1; c.aluop = fn; end
            PH_ALUWB:   begin c.rw = 1; c.rdst = 1; c.done = 1; end
            PH_IMMEXEC: begin
                c.srca = 1; c.srcb = 2'b10;
                c.aluop = (op == 4'd6) ? 3'd2 : (op == 4'd7) ? 3'd3 : 3'd0;
            end
            PH_IMMWB:   begin c.rw = 1; c.done = 1; end
            PH_MEMADR:  begin c.srca = 1; c.srcb = 2'b10; end
            PH_MEMRD:   begin c.mr = 1; c.iord = 1; c.err = tmo; end
            PH_MEMWB:   begin c.rw = 1; c.m2r = 1; c.done = 1; end
            PH_MEMWR:   begin c.mw = !tmo; c.iord = 1; c.done = rdy; c.err = tmo; end
            PH_BRANCH:  begin c.srca = 1; c.aluop = 3'd1; c.pcsrc = 2'b01; c.pcw = z; c.done = 1; end
            PH_JUMP:    begin c.pcsrc = 2'b10; c.pcw = 1; c.done = 1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic int base_latency(input logic [3:0] op);
        if (op >= 4'd8) return 2;
        case (op)
            4'd2:       return 5;
            4'd4, 4'd5: return 3;
            default:    return 4;
        endcase
    endfunction

    // Drive one cycle's inputs (opcode/funct scrambled where they must be ignored) and check
    task automatic drive_chk(input int ph, input logic rdy, input logic tmo);
        ctl_t got;
        bit   sens_op = (ph == PH_DECODE) || (ph == PH_MEMADR) || (ph == PH_IMMEXEC);
        bus.opcode    = sens_op ? cur_op : 4'($urandom);
        bus.funct     = (ph == PH_EXEC) ? cur_fn : 3'($urandom);
        bus.zero      = (ph == PH_BRANCH) ? cur_z : 1'($urandom);
        bus.mem_ready = rdy;
        #1;
        got = sample();
        icyc++;
        if (got.done && done_at < 0) done_at = icyc;
        check_eq($sformatf("ph%0d_op%0h", ph, cur_op), 32'(got),
                 32'(model(ph, rdy, cur_z, cur_op, cur_fn, tmo)));
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int ph, input logic rdy, input logic tmo);
        drive_chk(ph, rdy, tmo);
        advance();
    endtask

    // Memory wait phase: nwait not-ready cycles, or stuck until the timeout fires
    task automatic wait_phase(input int ph, input int nwait, input bit stuck, output bit aborted);
        aborted = 1'b0;
        for (int i = 0; i <= int'(TMO); i++) begin
            logic rdy = stuck ? 1'b0 : (i >= nwait);
            logic tmo = !rdy && (i == int'(TMO));
            cyc(ph, rdy, tmo);
            if (tmo) begin aborted = 1'b1; break; end
            if (rdy) break;
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [2:0] fn, input logic z,
                             input int fwait, input int mwait, input bit fstuck, input bit mstuck);
        bit ab;
        cur_op = op; cur_fn = fn; cur_z = z;
        icyc = 0; done_at = -1;
        wait_phase(PH_FETCH, fwait, fstuck, ab);
        if (ab) return;
        cyc(PH_DECODE, 1'b1, 1'b0);
        if (op < 4'd8) begin
            case (op)
                4'd0: begin cyc(PH_EXEC, 1, 0); cyc(PH_ALUWB, 1, 0); end
                4'd1, 4'd6, 4'd7: begin cyc(PH_IMMEXEC, 1, 0); cyc(PH_IMMWB, 1, 0); end
                4'd2: begin
                    cyc(PH_MEMADR, 1, 0);
                    wait_phase(PH_MEMRD, mwait, mstuck, ab);
                    if (ab) return;
                    cyc(PH_MEMWB, 1, 0);
                end
                4'd3: begin
                    cyc(PH_MEMADR, 1, 0);
                    wait_phase(PH_MEMWR, mwait, mstuck, ab);
                    if (ab) return;
                end
                4'd4: cyc(PH_BRANCH, 1, 0);
                default: cyc(PH_JUMP, 1, 0);
            endcase
        end
        check_eq($sformatf("latency_op%0h", op), 32'(done_at),
                 32'(base_latency(op) + fwait + ((op == 4'd2 || op == 4'd3) ? mwait : 0)));
    endtask

    initial begin
        rst_n = 1'b0;
        bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        cur_op = '0; cur_fn = '0; cur_z = 1'b0; icyc = 0; done_at = -1;

        // Reset: all outputs 0 even with mem_ready high
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outs", 32'(sample()), 32'(0));
        advance();
        check_eq("reset_outs2", 32'(sample()), 32'(0));
        rst_n = 1'b1;
        cyc(PH_IDLE, 1'b1, 1'b0);

        // Directed: SUB, LW with 3 waits, BEQ both ways, illegal, jump
        run_instr(4'd0, 3'd1, 1'b0, 0, 0, 0, 0);
        run_instr(4'd2, 3'd0, 1'b0, 0, 3, 0, 0);
        run_instr(4'd4, 3'd0, 1'b1, 0, 0, 0, 0);
        run_instr(4'd4, 3'd0, 1'b0, 0, 0, 0, 0);
        run_instr(4'hA, 3'd0, 1'b0, 0, 0, 0, 0);
        run_instr(4'd5, 3'd0, 1'b0, 0, 0, 0, 0);

        // Ready exactly at the limit completes normally
        run_instr(4'd3, 3'd0, 1'b0, TMO, TMO, 0, 0);

        // Timeouts in MEMWR, MEMRD and FETCH
        run_instr(4'd3, 3'd0, 1'b0, 0, 0, 0, 1);
        run_instr(4'd2, 3'd0, 1'b0, 0, 0, 0, 1);
        run_instr(4'd0, 3'd0, 1'b0, 0, 0, 1, 0);
        run_instr(4'd7, 3'd0, 1'b0, 0, 0, 0, 0);

        // Reset asserted during MEMWB
        cur_op = 4'd2; cur_fn = 3'd0; cur_z = 1'b0; icyc = 0; done_at = -1;
        cyc(PH_FETCH, 1, 0);
        cyc(PH_DECODE, 1, 0);
        cyc(PH_MEMADR, 1, 0);
        cyc(PH_MEMRD, 1, 0);
        drive_chk(PH_MEMWB, 1, 0);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_outs", 32'(sample()), 32'(0));
        check_eq("rst_mid_regwrite", 32'(bus.regwrite), 32'(0));
        advance();
        check_eq("rst_hold_outs", 32'(sample()), 32'(0));
        rst_n = 1'b1;
        cyc(PH_IDLE, 1'b1, 1'b0);

        // Randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            logic [3:0] op = 4'($urandom_range(0, 15));
            logic [2:0] fn = 3'($urandom);
            logic       z  = 1'($urandom);
            int fw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TMO)) : 0;
            int mw = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, TMO)) : 0;
            bit fs = ($urandom_range(0, 24) == 0);
            bit ms = ($urandom_range(0, 9) == 0);
            run_instr(op, fn, z, fw, mw, fs, ms);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
